// File: rtl/memoria_ram_scan_if.sv
// Host-side bus of the scanned RAM: the board drives addresses, data and strobes.
// The RAM answers with read data, its address, a valid pulse and a busy flag.
interface memoria_ram_scan_if #(
    parameter int N = 3,
    parameter int M = 8
);
    logic [N-1:0] addr_i;
    logic [M-1:0] dato_write_i;
    logic         wren_i;
    logic         rden_i;
    logic         clr_i;
    logic         scan_i;
    logic [M-1:0] dato_read_o;
    logic         valid_o;
    logic [N-1:0] addr_o;
    logic         busy_o;

    modport master (
        output addr_i, dato_write_i, wren_i, rden_i, clr_i, scan_i,
        input  dato_read_o, valid_o, addr_o, busy_o
    );

    modport slave (
        input  addr_i, dato_write_i, wren_i, rden_i, clr_i, scan_i,
        output dato_read_o, valid_o, addr_o, busy_o
    );
endinterface

// File: rtl/memoria_ram_scan.sv
// Single-port RAM with registered read, a sweep-clear engine and an auto-scan mode.
// The last word read is shown on a multiplexed hex 7-segment display.
module memoria_ram_scan #(
    parameter int N        = 3,
    parameter int M        = 8,
    parameter int SCAN_DIV = 4,
    parameter int REFRESH  = 1000,
    localparam int DIGITS  = (M + 3) / 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    memoria_ram_scan_if.slave   bus,
    output logic [0:6]          display_o,
    output logic [DIGITS-1:0]   digit_en_o
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCAN
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [M-1:0]  mem [2**N];

    logic [N-1:0]  clr_addr;
    logic [N-1:0]  scan_addr;
    logic [SW-1:0] scan_cnt;
    logic          scan_pending;

    logic [M-1:0]  dato_read;
    logic [N-1:0]  read_addr;
    logic          valid;

    logic          mem_we;
    logic [N-1:0]  mem_waddr;
    logic [M-1:0]  mem_wdata;
    logic          rd_en;
    logic [N-1:0]  rd_addr;
    logic          scan_tick;
    logic          scan_req;
    logic          scan_issue;
    logic          scan_defer;

    logic [RW-1:0] refresh_cnt;
    logic [DW-1:0] digit_idx;
    logic          display_on;
    logic [PW-1:0] padded;
    logic [PW-1:0] shifted;
    logic [3:0]    nibble;
    logic [0:6]    segments;

    assign bus.dato_read_o = dato_read;
    assign bus.addr_o      = read_addr;
    assign bus.valid_o     = valid;
    assign bus.busy_o      = (state == CLEAR);

    // Next-state and per-cycle RAM port arbitration between host, clear engine and scanner
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = bus.addr_i;
        mem_wdata  = bus.dato_write_i;
        rd_en      = 1'b0;
        rd_addr    = bus.addr_i;
        scan_issue = 1'b0;
        scan_defer = 1'b0;
        scan_tick  = (scan_cnt == SW'(SCAN_DIV - 1));
        scan_req   = scan_tick | scan_pending;

        case (state)
            IDLE: begin
                if (bus.clr_i) begin
                    state_next = CLEAR;
                end else if (bus.scan_i) begin
                    state_next = SCAN;
                end else if (bus.wren_i) begin
                    mem_we = 1'b1;
                end else if (bus.rden_i) begin
                    rd_en = 1'b1;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
                if (clr_addr == '1) begin
                    state_next = IDLE;
                end
            end
            SCAN: begin
                if (bus.clr_i) begin
                    state_next = CLEAR;
                end else begin
                    if (!bus.scan_i) begin
                        state_next = IDLE;
                    end
                    if (bus.wren_i) begin
                        mem_we     = 1'b1;
                        scan_defer = scan_req & bus.scan_i;
                    end else if (scan_req && bus.scan_i) begin
                        rd_en      = 1'b1;
                        rd_addr    = scan_addr;
                        scan_issue = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!rst_ni) begin
            mem_we = 1'b0;
            rd_en  = 1'b0;
        end
    end

    // State register plus clear/scan bookkeeping; scan counters restart on every SCAN entry
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            clr_addr     <= '0;
            scan_cnt     <= '0;
            scan_addr    <= '0;
            scan_pending <= 1'b0;
        end else begin
            state    <= state_next;
            clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
            if (state == SCAN && state_next == SCAN) begin
                scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
                if (scan_issue) begin
                    scan_addr <= scan_addr + 1'b1;
                end
                if (scan_defer) begin
                    scan_pending <= 1'b1;
                end else if (scan_issue) begin
                    scan_pending <= 1'b0;
                end
            end else begin
                scan_cnt     <= '0;
                scan_addr    <= '0;
                scan_pending <= 1'b0;
            end
        end
    end

    // RAM array write port; contents intentionally survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port; the word and its address hold until the next read
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dato_read <= '0;
            read_addr <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= rd_en;
            if (rd_en) begin
                dato_read <= mem[rd_addr];
                read_addr <= rd_addr;
            end
        end
    end

    // Digit multiplex timer: advance the active digit every REFRESH cycles
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            display_on  <= 1'b0;
        end else begin
            display_on <= 1'b1;
            if (refresh_cnt == RW'(REFRESH - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == DW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

    // Pick the active nibble, zero-extending the word to whole hex digits
    always_comb begin
        padded  = PW'(dato_read);
        shifted = padded >> {digit_idx, 2'b00};
        nibble  = shifted[3:0];
    end

    // Hex to segments a..g, active-high
    always_comb begin
        segments = 7'b0000000;
        case (nibble)
            4'h0: segments = 7'b1111110;
            4'h1: segments = 7'b0110000;
            4'h2: segments = 7'b1101101;
            4'h3: segments = 7'b1111001;
            4'h4: segments = 7'b0110011;
            4'h5: segments = 7'b1011011;
            4'h6: segments = 7'b1011111;
            4'h7: segments = 7'b1110000;
            4'h8: segments = 7'b1111111;
            4'h9: segments = 7'b1111011;
            4'hA: segments = 7'b1110111;
            4'hB: segments = 7'b0011111;
            4'hC: segments = 7'b1001110;
            4'hD: segments = 7'b0111101;
            4'hE: segments = 7'b1001111;
            4'hF: segments = 7'b1000111;
            default: segments = 7'b0000000;
        endcase
    end

    // Display outputs: dark while in reset, otherwise the decoded active digit
    always_comb begin
        digit_en_o            = '0;
        digit_en_o[digit_idx] = 1'b1;
        display_o             = display_on ? segments : 7'b0000000;
    end

endmodule

// File: tb/tb_memoria_ram_scan.sv
// Self-checking bench for memoria_ram_scan: a cycle-level behavioural model
// compared every cycle, plus directed checks with hand-computed values.
module tb_memoria_ram_scan;

    localparam int N        = 3;
    localparam int M        = 8;
    localparam int SCAN_DIV = 4;
    localparam int REFRESH  = 2;
    localparam int DIGITS   = 2;
    localparam int DEPTH    = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [0:6]        display_o;
    logic [DIGITS-1:0] digit_en_o;

    memoria_ram_scan_if #(.N(N), .M(M)) bus ();

    memoria_ram_scan #(
        .N(N), .M(M), .SCAN_DIV(SCAN_DIV), .REFRESH(REFRESH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bus        (bus),
        .display_o  (display_o),
        .digit_en_o (digit_en_o)
    );

    // Free-running 10-unit clock
    always #5 clk_i = ~clk_i;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    logic [0:6] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Model state
    int         m_mode = 0;
    logic [7:0] m_mem [DEPTH];
    int         m_clr_idx = 0;
    int         m_scan_cyc = 0;
    int         m_scan_next = 0;
    bit         m_pending = 1'b0;
    bit         m_due;
    logic       exp_valid = 1'b0;
    logic       exp_busy = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic [2:0] exp_addr = 3'd0;
    bit         disp_on = 1'b0;
    int         disp_edges = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: drive at a falling edge, return at the next falling edge
    task automatic applyStimulus(input logic wren, input logic rden, input logic clr,
                                 input logic scan, input logic [2:0] addr, input logic [7:0] data);
        bus.wren_i       = wren;
        bus.rden_i       = rden;
        bus.clr_i        = clr;
        bus.scan_i       = scan;
        bus.addr_i       = addr;
        bus.dato_write_i = data;
        @(negedge clk_i);
    endtask

    // Behavioural model: IDLE/CLEAR/SCAN rules, scan ticks from cycles since entry
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_mode     = 0;
            exp_valid  = 1'b0;
            exp_data   = 8'h00;
            exp_addr   = 3'd0;
            disp_on    = 1'b0;
            disp_edges = 0;
        end else begin
            exp_valid = 1'b0;
            disp_on   = 1'b1;
            disp_edges++;
            case (m_mode)
                0: begin
                    if (bus.clr_i) begin
                        m_mode = 1; m_clr_idx = 0;
                    end else if (bus.scan_i) begin
                        m_mode = 2; m_scan_cyc = 0; m_scan_next = 0; m_pending = 1'b0;
                    end else if (bus.wren_i) begin
                        m_mem[bus.addr_i] = bus.dato_write_i;
                    end else if (bus.rden_i) begin
                        exp_valid = 1'b1; exp_addr = bus.addr_i; exp_data = m_mem[bus.addr_i];
                    end
                end
                1: begin
                    m_mem[m_clr_idx] = 8'h00;
                    if (m_clr_idx == DEPTH - 1) m_mode = 0;
                    else m_clr_idx++;
                end
                default: begin
                    if (bus.clr_i) begin
                        m_mode = 1; m_clr_idx = 0;
                    end else begin
                        m_due = ((m_scan_cyc % SCAN_DIV) == SCAN_DIV - 1) || m_pending;
                        if (bus.wren_i) begin
                            m_mem[bus.addr_i] = bus.dato_write_i;
                            if (m_due && bus.scan_i) m_pending = 1'b1;
                        end else if (m_due && bus.scan_i) begin
                            exp_valid   = 1'b1;
                            exp_addr    = 3'(m_scan_next);
                            exp_data    = m_mem[m_scan_next];
                            m_scan_next = (m_scan_next + 1) % DEPTH;
                            m_pending   = 1'b0;
                        end
                        m_scan_cyc++;
                        if (!bus.scan_i) m_mode = 0;
                    end
                end
            endcase
        end
        exp_busy = (m_mode == 1);
    end

    // Every-cycle compare of all DUT outputs against the model
    always @(negedge clk_i) begin
        int idx;
        logic [7:0] shifted;
        if (check_en) begin
            idx     = (disp_edges / REFRESH) % DIGITS;
            shifted = exp_data >> (4 * idx);
            checkOutput("valid_o",    32'(bus.valid_o),     32'(exp_valid));
            checkOutput("busy_o",     32'(bus.busy_o),      32'(exp_busy));
            checkOutput("dato_read_o", 32'(bus.dato_read_o), 32'(exp_data));
            checkOutput("addr_o",     32'(bus.addr_o),      32'(exp_addr));
            checkOutput("digit_en_o", 32'(digit_en_o),      32'(1 << idx));
            checkOutput("display_o",  32'(display_o),
                        disp_on ? 32'(seg_tab[shifted[3:0]]) : 32'h0);
        end
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    int busy_cycles;
    int v_j [$];
    int v_a [$];
    int v_d [$];
    int ones;

    initial begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
        bus.wren_i = 1'b0; bus.rden_i = 1'b0; bus.clr_i = 1'b0; bus.scan_i = 1'b0;
        bus.addr_i = '0; bus.dato_write_i = '0;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check_en = 1'b1;
        checkOutput("reset valid_o", 32'(bus.valid_o), 32'h0);
        checkOutput("reset busy_o", 32'(bus.busy_o), 32'h0);
        checkOutput("reset dato_read_o", 32'(bus.dato_read_o), 32'h0);
        checkOutput("reset display_o", 32'(display_o), 32'h0);
        checkOutput("reset digit_en_o", 32'(digit_en_o), 32'h1);
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);

        // Write then read back one word
        applyStimulus(1, 0, 0, 0, 3'd3, 8'hA5);
        applyStimulus(0, 1, 0, 0, 3'd3, 8'h00);
        checkOutput("read valid", 32'(bus.valid_o), 32'h1);
        checkOutput("read data", 32'(bus.dato_read_o), 32'hA5);
        checkOutput("read addr", 32'(bus.addr_o), 32'h3);
        applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);
        checkOutput("valid one cycle", 32'(bus.valid_o), 32'h0);
        checkOutput("read data holds", 32'(bus.dato_read_o), 32'hA5);

        // Fill with 0xFF, sweep-clear, read everything back as zero
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, 0, 0, 0, 3'(k), 8'hFF);
        applyStimulus(0, 0, 1, 0, 3'd0, 8'h00);
        busy_cycles = 0;
        for (int j = 0; j < 12; j++) begin
            if (bus.busy_o) busy_cycles++;
            applyStimulus(1, 1, 0, 1, 3'd2, 8'h77);
            if (j == 0) checkOutput("clear keeps read data", 32'(bus.dato_read_o), 32'hA5);
            bus.wren_i = 1'b0; bus.rden_i = 1'b0; bus.scan_i = 1'b0;
            if (j >= 7) break;
        end
        for (int j = 0; j < 4; j++) begin
            if (bus.busy_o) busy_cycles++;
            applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);
        end
        checkOutput("busy cycle count", 32'(busy_cycles), 32'd8);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(0, 1, 0, 0, 3'(k), 8'h00);
            checkOutput("cleared word", 32'(bus.dato_read_o), 32'h00);
        end

        // Auto-scan over 0x10+k with wrap
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, 0, 0, 0, 3'(k), 8'(8'h10 + k));
        applyStimulus(0, 0, 0, 1, 3'd0, 8'h00);
        v_j.delete(); v_a.delete(); v_d.delete();
        for (int j = 0; j <= 40; j++) begin
            if (bus.valid_o) begin
                v_j.push_back(j); v_a.push_back(int'(bus.addr_o)); v_d.push_back(int'(bus.dato_read_o));
            end
            applyStimulus(0, 0, 0, (j < 36), 3'd0, 8'h00);
        end
        checkOutput("scan read count", 32'(v_j.size()), 32'd9);
        for (int k = 0; k < v_j.size() && k < 9; k++) begin
            checkOutput("scan timing", 32'(v_j[k]), 32'(4 * (k + 1)));
            checkOutput("scan addr", 32'(v_a[k]), 32'(k % 8));
            checkOutput("scan data", 32'(v_d[k]), 32'(8'h10 + (k % 8)));
        end

        // Write landing on a scan tick defers that read by one cycle
        applyStimulus(0, 0, 0, 1, 3'd0, 8'h00);
        v_j.delete(); v_a.delete(); v_d.delete();
        for (int j = 0; j <= 30; j++) begin
            if (bus.valid_o) begin
                v_j.push_back(j); v_a.push_back(int'(bus.addr_o)); v_d.push_back(int'(bus.dato_read_o));
            end
            applyStimulus((j == 3), 0, 0, (j < 28), 3'd5, 8'h55);
        end
        checkOutput("deferred read count", 32'(v_j.size()), 32'd7);
        if (v_j.size() == 7) begin
            checkOutput("deferred first timing", 32'(v_j[0]), 32'd5);
            checkOutput("deferred first data", 32'(v_d[0]), 32'h10);
            checkOutput("second tick timing", 32'(v_j[1]), 32'd8);
            for (int k = 0; k < 7; k++) checkOutput("no skipped addr", 32'(v_a[k]), 32'(k));
            checkOutput("written word seen", 32'(v_d[5]), 32'h55);
        end

        // Display alternation for 0x3C
        applyStimulus(1, 0, 0, 0, 3'd1, 8'h3C);
        applyStimulus(0, 1, 0, 0, 3'd1, 8'h00);
        ones = 0;
        for (int j = 0; j < 8; j++) begin
            if (digit_en_o == 2'b01) begin
                ones++;
                checkOutput("digit0 shows C", 32'(display_o), 32'(7'b1001110));
            end else begin
                checkOutput("digit1 enable", 32'(digit_en_o), 32'h2);
                checkOutput("digit1 shows 3", 32'(display_o), 32'(7'b1111001));
            end
            applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);
        end
        checkOutput("digit0 slot count", 32'(ones), 32'd4);

        // Reset during the 4th CLEAR cycle
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, 0, 0, 0, 3'(k), 8'(8'h20 + k));
        applyStimulus(0, 0, 1, 0, 3'd0, 8'h00);
        for (int j = 0; j < 3; j++) applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);
        rst_ni = 1'b0;
        applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);
        checkOutput("reset busy_o", 32'(bus.busy_o), 32'h0);
        checkOutput("reset read data", 32'(bus.dato_read_o), 32'h0);
        checkOutput("reset addr_o", 32'(bus.addr_o), 32'h0);
        checkOutput("reset digit_en", 32'(digit_en_o), 32'h1);
        checkOutput("reset display", 32'(display_o), 32'h0);
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(0, 1, 0, 0, 3'(k), 8'h00);
            checkOutput("partial clear word", 32'(bus.dato_read_o), (k < 3) ? 32'h0 : 32'(8'h20 + k));
        end
        applyStimulus(0, 0, 0, 0, 3'd0, 8'h00);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
